// File: rtl/my_pipe_adder_pkg.sv
// my_pipe_adder_pkg
//  Shared definitions for the pipelined add/subtract unit.
//  - mode_e       : operation select (MODE_ADD = 0, MODE_SUB = 1)
//  - chunk_width(): bits handled per pipeline stage (WIDTH / STAGES)
package my_pipe_adder_pkg;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } mode_e;

    // WIDTH must be an exact multiple of STAGES; the remainder is not handled.
    function automatic int chunk_width(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/my_pipe_adder_if.sv
// my_pipe_adder_if
//  Operand and result handshake bundle for my_pipe_adder.
//  Ports (all WIDTH-bit buses unless noted):
//    in_valid/in_ready (1)  operand beat handshake
//    in_a, in_b             operands
//    in_cin (1)             carry-in, add mode only
//    in_sub (1)             0 = A+B+cin, 1 = A-B
//    out_valid/out_ready(1) result beat handshake
//    out_sum                result
//    out_cout (1)           carry out of MSB (sub: 1 = no borrow)
//    out_ovf (1)            signed overflow
//    out_zero (1)           out_sum == 0
//  Modports: master = producer/consumer side, slave = the adder.
interface my_pipe_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic             out_zero;

    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
    );
endinterface

// File: rtl/my_pipe_adder_chunk.sv
// my_pipe_adder_chunk
//  Combinational CHUNK-bit ripple-carry adder made of per-bit full adders.
//  Ports:
//    i_a, i_b  (CHUNK)  chunk operands
//    i_cin     (1)      carry into bit 0
//    o_sum     (CHUNK)  chunk sum
//    o_cout    (1)      carry out of the top bit
module my_pipe_adder_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_cin,
    output logic [CHUNK-1:0] o_sum,
    output logic             o_cout
);
    logic w_carry;

    always_comb begin
        w_carry = i_cin;
        o_sum   = '0;
        for (int i = 0; i < CHUNK; i++) begin
            o_sum[i] = i_a[i] ^ i_b[i] ^ w_carry;
            w_carry  = (i_a[i] & i_b[i]) | (w_carry & (i_a[i] ^ i_b[i]));
        end
        o_cout = w_carry;
    end
endmodule

// File: rtl/my_pipe_adder.sv
// my_pipe_adder
//  Pipelined add/subtract unit. A WIDTH-bit add is split into STAGES chunks of
//  CHUNK = WIDTH/STAGES bits; stage k adds chunk k using the carry registered by
//  stage k-1. Latency STAGES cycles, throughput one beat per cycle. Empty stages
//  are filled from behind (bubbles collapse) and a stalled output only holds
//  the stages that are actually blocked.
//  Ports:
//    clk    (1)  rising-edge clock
//    reset  (1)  asynchronous active-high reset, clears every stage
//    bus         my_pipe_adder_if.slave handshake/data bundle
module my_pipe_adder
    import my_pipe_adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    my_pipe_adder_if.slave       bus
);
    localparam int CHUNK = chunk_width(WIDTH, STAGES);
    localparam int MSB   = WIDTH - 1;

    // Values presented to stage k (index 0 comes straight from the input port).
    logic [WIDTH-1:0]  w_a   [STAGES];
    logic [WIDTH-1:0]  w_b   [STAGES];   // already inverted in sub mode
    logic [WIDTH-1:0]  w_s   [STAGES];   // low chunks finished so far
    logic [STAGES-1:0] w_cin;
    logic [STAGES-1:0] w_vin;
    logic [STAGES-1:0] w_valid;
    logic [STAGES-1:0] w_load;
    mode_e             w_mode;

    assign w_mode   = bus.in_sub ? MODE_SUB : MODE_ADD;
    assign w_a[0]   = bus.in_a;
    assign w_b[0]   = (w_mode == MODE_SUB) ? ~bus.in_b : bus.in_b;
    assign w_s[0]   = '0;
    assign w_cin[0] = (w_mode == MODE_SUB) ? 1'b1 : bus.in_cin;
    assign w_vin[0] = bus.in_valid;

    // A stage register may load when it is empty or its content moves on.
    // Evaluated from the output backwards in one block so the chain stays a
    // simple ordered computation.
    always_comb begin
        w_load = '0;
        w_load[STAGES-1] = ~w_valid[STAGES-1] | bus.out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            w_load[k] = ~w_valid[k] | w_load[k+1];
        end
    end

    assign bus.in_ready = w_load[0];

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            logic [CHUNK-1:0] w_chunk_sum;
            logic             w_chunk_cout;
            logic [WIDTH-1:0] w_s_next;

            my_pipe_adder_chunk #(
                .CHUNK (CHUNK)
            ) u_chunk (
                .i_a    (w_a[gi][gi*CHUNK +: CHUNK]),
                .i_b    (w_b[gi][gi*CHUNK +: CHUNK]),
                .i_cin  (w_cin[gi]),
                .o_sum  (w_chunk_sum),
                .o_cout (w_chunk_cout)
            );

            always_comb begin
                w_s_next = w_s[gi];
                w_s_next[gi*CHUNK +: CHUNK] = w_chunk_sum;
            end

            if (gi < STAGES - 1) begin : g_mid
                logic             r_valid;
                logic [WIDTH-1:0] r_a;
                logic [WIDTH-1:0] r_b;
                logic [WIDTH-1:0] r_s;
                logic             r_c;

                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        r_valid <= 1'b0;
                        r_a     <= '0;
                        r_b     <= '0;
                        r_s     <= '0;
                        r_c     <= 1'b0;
                    end else if (w_load[gi]) begin
                        r_valid <= w_vin[gi];
                        r_a     <= w_a[gi];
                        r_b     <= w_b[gi];
                        r_s     <= w_s_next;
                        r_c     <= w_chunk_cout;
                    end
                end

                assign w_valid[gi]   = r_valid;
                assign w_vin[gi+1]   = r_valid;
                assign w_a[gi+1]     = r_a;
                assign w_b[gi+1]     = r_b;
                assign w_s[gi+1]     = r_s;
                assign w_cin[gi+1]   = r_c;
            end else begin : g_last
                // Output register: flags are registered here rather than
                // decoded from out_sum, so reset clears them independently.
                logic             r_valid;
                logic [WIDTH-1:0] r_s;
                logic             r_cout;
                logic             r_ovf;
                logic             r_zero;

                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        r_valid <= 1'b0;
                        r_s     <= '0;
                        r_cout  <= 1'b0;
                        r_ovf   <= 1'b0;
                        r_zero  <= 1'b0;
                    end else if (w_load[gi]) begin
                        r_valid <= w_vin[gi];
                        r_s     <= w_s_next;
                        r_cout  <= w_chunk_cout;
                        r_ovf   <= (w_a[gi][MSB] == w_b[gi][MSB]) &&
                                   (w_s_next[MSB] != w_a[gi][MSB]);
                        r_zero  <= (w_s_next == '0);
                    end
                end

                assign w_valid[gi]   = r_valid;
                assign bus.out_valid = r_valid;
                assign bus.out_sum   = r_s;
                assign bus.out_cout  = r_cout;
                assign bus.out_ovf   = r_ovf;
                assign bus.out_zero  = r_zero;
            end
        end
    endgenerate
endmodule

// File: tb/tb_my_pipe_adder.sv
// tb_my_pipe_adder
//  Directed tests of my_pipe_adder (WIDTH=16, STAGES=4): reset mid-stream,
//  carry ripple, overflow/sub, backpressure, bubble collapse, plus a random
//  valid/ready stream checked by a scoreboard.
module tb_my_pipe_adder;
    localparam int WIDTH  = 16;
    localparam int STAGES = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    my_pipe_adder_if #(.WIDTH(WIDTH)) bus ();

    my_pipe_adder #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_rx     = 0;
    bit          sb_en    = 1'b0;
    logic [18:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: {zero, ovf, cout, sum}
    function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic sub);
        logic [15:0] bp;
        logic        c0;
        logic [16:0] t;
        logic        ovf;
        logic        zero;
        bp   = sub ? ~b : b;
        c0   = sub ? 1'b1 : cin;
        t    = {1'b0, a} + {1'b0, bp} + {16'd0, c0};
        ovf  = (a[15] == bp[15]) && (t[15] != a[15]);
        zero = (t[15:0] == 16'd0);
        return {zero, ovf, t[16], t[15:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sub);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_cin   = cin;
        bus.in_sub   = sub;
    endtask

    task automatic check_out(input string tag, input logic [15:0] sum, input logic cout,
                             input logic ovf, input logic zero);
        check(tag, 32'({bus.out_valid, bus.out_zero, bus.out_ovf, bus.out_cout, bus.out_sum}),
                   32'({1'b1, zero, ovf, cout, sum}));
    endtask

    // Scoreboard: handshakes are sampled on the falling edge, i.e. the values
    // that complete on the following rising edge.
    always @(negedge clk) begin
        if (sb_en) begin
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_extra", 32'd1, 32'd0);
                end else begin
                    check("sb_beat",
                          32'({bus.out_zero, bus.out_ovf, bus.out_cout, bus.out_sum}),
                          32'(exp_q.pop_front()));
                end
                $display("beat %0d: sum=%h cout=%b ovf=%b zero=%b",
                         n_rx, bus.out_sum, bus.out_cout, bus.out_ovf, bus.out_zero);
                n_rx++;
            end
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back(model(bus.in_a, bus.in_b, bus.in_cin, bus.in_sub));
        end
    end

    task automatic drain(input string tag);
        int waited;
        waited = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        while ((exp_q.size() != 0 || bus.out_valid) && waited < 100) begin
            tick();
            waited++;
        end
        check({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        acc;
        logic [15:0] ra;
        logic [15:0] rb;
        int          idx;
        int          cyc;
        int          sent;
        bit          have;

        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_cin    = 1'b0;
        bus.in_sub    = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_out", 32'({bus.out_valid, bus.out_cout, bus.out_ovf, bus.out_zero, bus.out_sum}), 32'd0);
        reset = 1'b0;
        tick();
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Carry ripple through every chunk, latency STAGES
        bus.out_ready = 1'b1;
        drive(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        check("t2_early", 32'(bus.out_valid), 32'd0);
        tick();
        check_out("t2_ripple", 16'h0000, 1'b1, 1'b0, 1'b1);
        tick();
        check("t2_drained", 32'(bus.out_valid), 32'd0);

        // Signed overflow, then subtract with borrow
        drive(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        tick();
        drive(16'h0005, 16'h0007, 1'b1, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        check_out("t3_ovf", 16'h8000, 1'b0, 1'b1, 1'b0);
        tick();
        check_out("t3_sub", 16'hFFFE, 1'b0, 1'b0, 1'b0);
        tick();

        // Reset with beats in flight
        for (int i = 0; i < 4; i++) begin
            drive(16'h1111 * 16'(i + 1), 16'h0101, 1'b0, 1'b0);
            tick();
        end
        check("t1_pre", 32'(bus.out_valid), 32'd1);
        bus.in_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("t1_async", 32'({bus.out_valid, bus.out_cout, bus.out_ovf, bus.out_zero, bus.out_sum}), 32'd0);
        tick();
        reset = 1'b0;
        drive(16'h1234, 16'h4321, 1'b1, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        check("t1_flushed", 32'(bus.out_valid), 32'd0);
        tick();
        tick();
        check("t1_early", 32'(bus.out_valid), 32'd0);
        tick();
        check_out("t1_first", 16'h5556, 1'b0, 1'b0, 1'b0);
        tick();

        // Bubble collapse: beats at cycles 0 and 3, consumer ready from cycle 8
        for (int c = 0; c < 11; c++) begin
            if (c == 0)      drive(16'h00FF, 16'h0F01, 1'b0, 1'b0);
            else if (c == 3) drive(16'h8000, 16'h0001, 1'b0, 1'b1);
            else             bus.in_valid = 1'b0;
            bus.out_ready = (c >= 8);
            if (c == 7) begin
                check_out("t5_first", 16'h1000, 1'b0, 1'b0, 1'b0);
                check("t5_in_ready", 32'(bus.in_ready), 32'd1);
            end
            if (c == 9)  check_out("t5_second", 16'h7FFF, 1'b1, 1'b1, 1'b0);
            if (c == 10) check("t5_empty", 32'(bus.out_valid), 32'd0);
            tick();
        end

        // Backpressure: 8 beats back-to-back, consumer stalled for 6 cycles
        sb_en = 1'b1;
        n_rx  = 0;
        bus.out_ready = 1'b0;
        idx = 0;
        cyc = 0;
        while (idx < 8 && cyc < 100) begin
            if (cyc == 6) bus.out_ready = 1'b1;
            drive(16'h1000 * 16'(idx) + 16'h0123, 16'h0F0F ^ (16'h1111 * 16'(idx)),
                  idx[1], idx[0]);
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            if (cyc == 5) check("t4_stall", 32'(bus.in_ready), 32'd0);
            @(posedge clk);
            #1;
            if (acc) idx++;
            cyc++;
        end
        check("t4_sent", 32'(idx), 32'd8);
        drain("t4_drain");
        check("t4_count", 32'(n_rx), 32'd8);

        // Random valid/ready stream
        n_rx = 0;
        sent = 0;
        have = 1'b0;
        cyc  = 0;
        while (sent < 400 && cyc < 5000) begin
            if (!have && $urandom_range(3) != 0) begin
                case ($urandom_range(3))
                    0:       ra = 16'hFFFF;
                    1:       ra = 16'h7FFF;
                    default: ra = 16'($urandom);
                endcase
                rb = ($urandom_range(4) == 0) ? 16'h0001 : 16'($urandom);
                drive(ra, rb, 1'($urandom), 1'($urandom));
                have = 1'b1;
            end
            bus.in_valid  = have;
            bus.out_ready = ($urandom_range(3) != 0);
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                have = 1'b0;
                sent++;
            end
            cyc++;
        end
        check("t6_sent", 32'(sent), 32'd400);
        drain("t6_drain");
        check("t6_count", 32'(n_rx), 32'd400);
        sb_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
